// File: rtl/gate_chip_tester.sv
// Automated tester for 7404/7408/7432 gate chip models: steps through every input
// combination per gate, waits SETTLE cycles, then compares sensed outputs to expected values.
module gate_chip_tester #(
    parameter int SETTLE = 2,
    parameter int ERR_W  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       chip_sel,
    output logic [7:0]       drive,
    input  logic [5:0]       sense,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [5:0]       fail_mask,
    output logic [ERR_W-1:0] err_count
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [ERR_W+2:0] ERR_MAX = {3'b000, {ERR_W{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [1:0]       sel_reg, sel_next;
    logic [1:0]       vec_reg, vec_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [7:0]       drive_reg, drive_next;
    logic [5:0]       fail_mask_reg, fail_mask_next;
    logic [ERR_W-1:0] err_count_reg, err_count_next;

    logic [5:0]       mism;
    logic [2:0]       popcnt;
    logic [ERR_W+2:0] err_sum;
    logic             last_vec;

    // Gate input pattern for a given chip and vector index.
    function automatic logic [7:0] pattern(input logic [1:0] sel, input logic [1:0] vec);
        logic [7:0] p;
        logic [1:0] q;
        p = '0;
        if (sel == 2'b00) begin
            for (int g = 0; g < 6; g++) begin
                p[g] = vec[0] ^ g[0];
            end
        end else begin
            for (int g = 0; g < 4; g++) begin
                q = vec + 2'(g);
                p[2*g+1] = q[1];
                p[2*g]   = q[0];
            end
        end
        return p;
    endfunction

    // Expected values are derived from the drive value held since SETTLE began.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_gate
            if (gi < 4) begin : g_pair
                logic exp_two;
                assign exp_two = (sel_reg == 2'b01) ? (drive_reg[2*gi+1] & drive_reg[2*gi])
                                                    : (drive_reg[2*gi+1] | drive_reg[2*gi]);
                assign mism[gi] = (sel_reg == 2'b00) ? (sense[gi] ~^ drive_reg[gi])
                                                     : (sense[gi] ^ exp_two);
            end else begin : g_inv_only
                assign mism[gi] = (sel_reg == 2'b00) ? (sense[gi] ~^ drive_reg[gi]) : 1'b0;
            end
        end
    endgenerate

    always_comb begin
        popcnt = '0;
        for (int i = 0; i < 6; i++) begin
            popcnt = popcnt + 3'(mism[i]);
        end
    end

    assign err_sum  = {3'b000, err_count_reg} + {{ERR_W{1'b0}}, popcnt};
    assign last_vec = (sel_reg == 2'b00) ? (vec_reg == 2'd1) : (vec_reg == 2'd3);

    always_comb begin
        state_next     = state_reg;
        sel_next       = sel_reg;
        vec_next       = vec_reg;
        cnt_next       = cnt_reg;
        drive_next     = drive_reg;
        fail_mask_next = fail_mask_reg;
        err_count_next = err_count_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    sel_next       = chip_sel;
                    fail_mask_next = '0;
                    err_count_next = '0;
                    vec_next       = '0;
                    cnt_next       = '0;
                    if (chip_sel != 2'b11) begin
                        drive_next = pattern(chip_sel, 2'd0);
                        state_next = ST_SETTLE;
                    end else begin
                        drive_next = '0;
                        state_next = ST_DONE;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_reg == CW'(SETTLE - 1)) begin
                    state_next = ST_CHECK;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_CHECK: begin
                fail_mask_next = fail_mask_reg | mism;
                err_count_next = (err_sum > ERR_MAX) ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
                if (last_vec) begin
                    drive_next = '0;
                    state_next = ST_DONE;
                end else begin
                    vec_next   = vec_reg + 2'd1;
                    cnt_next   = '0;
                    drive_next = pattern(sel_reg, vec_reg + 2'd1);
                    state_next = ST_SETTLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            sel_reg       <= '0;
            vec_reg       <= '0;
            cnt_reg       <= '0;
            drive_reg     <= '0;
            fail_mask_reg <= '0;
            err_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            sel_reg       <= sel_next;
            vec_reg       <= vec_next;
            cnt_reg       <= cnt_next;
            drive_reg     <= drive_next;
            fail_mask_reg <= fail_mask_next;
            err_count_reg <= err_count_next;
        end
    end

    assign drive     = drive_reg;
    assign busy      = (state_reg == ST_SETTLE) || (state_reg == ST_CHECK);
    assign done      = (state_reg == ST_DONE);
    assign pass      = done && (sel_reg != 2'b11) && (err_count_reg == '0);
    assign fail_mask = fail_mask_reg;
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_gate_chip_tester.sv
// Bench for gate_chip_tester: a faultable chip model on the pins, random runs with start/sel
// noise during busy, and an expected-result model computed directly from the gate truth tables.
module tb_gate_chip_tester;

    localparam int SETTLE = 2;
    localparam int ERR_W  = 3;
    localparam int ERR_SAT = (1 << ERR_W) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       chip_sel;
    logic [7:0]       drive;
    logic [5:0]       sense;
    logic             busy, done, pass;
    logic [5:0]       fail_mask;
    logic [ERR_W-1:0] err_count;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         model_type = 0;
    logic [5:0] stuck0 = '0;
    logic [5:0] stuck1 = '0;

    gate_chip_tester #(.SETTLE(SETTLE), .ERR_W(ERR_W)) dut (
        .clock(clock), .reset(reset), .start(start), .chip_sel(chip_sel),
        .drive(drive), .sense(sense), .busy(busy), .done(done), .pass(pass),
        .fail_mask(fail_mask), .err_count(err_count)
    );

    always #5 clock = ~clock;

    // Chip on the bench: 0=7404, 1=7408, 2=7432, with stuck-at faults on outputs.
    function automatic logic [5:0] chip_out(input int m, input logic [7:0] d,
                                            input logic [5:0] s0, input logic [5:0] s1);
        logic [5:0] o;
        o = '0;
        for (int g = 0; g < 6; g++) begin
            if (m == 0) o[g] = ~d[g];
            else if (g < 4) o[g] = (m == 1) ? (d[2*g+1] & d[2*g]) : (d[2*g+1] | d[2*g]);
        end
        return (o & ~s0) | s1;
    endfunction

    assign sense = chip_out(model_type, drive, stuck0, stuck1);

    function automatic logic [7:0] ref_drive(input int sel, input int v);
        logic [7:0] d;
        int p;
        d = '0;
        if (sel == 0) begin
            for (int g = 0; g < 6; g++) d[g] = 1'((v % 2) ^ (g % 2));
        end else begin
            for (int g = 0; g < 4; g++) begin
                p = (v + g) % 4;
                d[2*g+1] = 1'(p / 2);
                d[2*g]   = 1'(p % 2);
            end
        end
        return d;
    endfunction

    task automatic ref_result(input int sel, output int e, output logic [5:0] m);
        int nv, ng, a, b, expv;
        logic [5:0] o;
        e = 0;
        m = '0;
        nv = (sel == 0) ? 2 : 4;
        ng = (sel == 0) ? 6 : 4;
        for (int v = 0; v < nv; v++) begin
            o = chip_out(model_type, ref_drive(sel, v), stuck0, stuck1);
            for (int g = 0; g < ng; g++) begin
                if (sel == 0) begin
                    expv = 1 - ((v % 2) ^ (g % 2));
                end else begin
                    a = ((v + g) % 4) / 2;
                    b = ((v + g) % 4) % 2;
                    expv = (sel == 1) ? (a & b) : (a | b);
                end
                if (int'(o[g]) != expv) begin
                    e++;
                    m[g] = 1'b1;
                end
            end
        end
        if (e > ERR_SAT) e = ERR_SAT;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic run(input int sel, input int m, input logic [5:0] s0, input logic [5:0] s1,
                       input bit noise);
        int total, e;
        logic [5:0] em;
        @(negedge clock);
        model_type = m;
        stuck0 = s0;
        stuck1 = s1;
        chip_sel = 2'(sel);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        if (sel == 3) begin
            check("ill_done", done, 1'b1);
            check("ill_busy", busy, 1'b0);
            check("ill_drive", drive, 8'h00);
            check("ill_err", err_count, 0);
            check("ill_mask", fail_mask, 6'b0);
            check("ill_pass", pass, 1'b0);
            $display("[TB] run sel=3 illegal done=%b pass=%b err=%0d", done, pass, err_count);
            return;
        end
        ref_result(sel, e, em);
        total = ((sel == 0) ? 2 : 4) * (SETTLE + 1);
        for (int k = 0; k < total; k++) begin
            check("run_drive", drive, ref_drive(sel, k / (SETTLE + 1)));
            check("run_busy", busy, 1'b1);
            check("run_done", done, 1'b0);
            if (noise) begin
                start = 1'($urandom % 2);
                chip_sel = 2'($urandom % 4);
            end
            @(posedge clock);
            #1;
        end
        start = 1'b0;
        check("end_done", done, 1'b1);
        check("end_busy", busy, 1'b0);
        check("end_drive", drive, 8'h00);
        check("end_err", err_count, e);
        check("end_mask", fail_mask, em);
        check("end_pass", pass, (e == 0));
        $display("[TB] run sel=%0d model=%0d s0=%b s1=%b err=%0d mask=%b pass=%b",
                 sel, m, s0, s1, err_count, fail_mask, pass);
    endtask

    initial begin
        int sel, m;
        logic [5:0] s0, s1;
        reset = 1'b1;
        start = 1'b0;
        chip_sel = 2'b00;
        repeat (2) @(posedge clock);
        #1;
        check("rst_drive", drive, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_mask", fail_mask, 6'b0);
        check("rst_err", err_count, 0);
        reset = 1'b0;

        run(1, 1, 6'b0, 6'b0, 1'b0);
        run(0, 0, 6'b0, 6'b0, 1'b0);
        run(2, 2, 6'b000100, 6'b0, 1'b0);
        run(1, 2, 6'b0, 6'b0, 1'b0);
        run(3, 1, 6'b0, 6'b0, 1'b0);
        run(0, 0, 6'b111111, 6'b0, 1'b1);

        // Reset in the third SETTLE cycle, after a fault has already been counted.
        @(negedge clock);
        model_type = 1;
        stuck0 = '0;
        stuck1 = 6'b000001;
        chip_sel = 2'b01;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("pre_rst_err", err_count, 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_drive", drive, 8'h00);
        check("mid_rst_err", err_count, 0);
        check("mid_rst_mask", fail_mask, 6'b0);
        $display("[TB] mid-run reset busy=%b done=%b drive=%h", busy, done, drive);
        run(1, 1, 6'b0, 6'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            sel = int'($urandom % 4);
            m = int'($urandom % 3);
            if ($urandom % 2 == 0) begin
                s0 = '0;
                s1 = '0;
            end else begin
                s0 = 6'($urandom);
                s1 = 6'($urandom) & ~s0;
            end
            run(sel, m, s0, s1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
